// File: rtl/uart_rx_if.sv
// Host-side receive port of uart_rx: FIFO pop, error clear, head byte and status.
interface uart_rx_if;
  logic       RxFifoRead;
  logic       ErrorClear;
  logic [7:0] RxData;
  logic       RxFifoEmpty;
  logic       RxFifoFull;
  logic       RxFrameError;
  logic       RxOverrun;

  modport master (
    output RxFifoRead, ErrorClear,
    input  RxData, RxFifoEmpty, RxFifoFull, RxFrameError, RxOverrun
  );

  modport slave (
    input  RxFifoRead, ErrorClear,
    output RxData, RxFifoEmpty, RxFifoFull, RxFrameError, RxOverrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling from a cycle counter, a first-word
// fall-through receive FIFO and sticky framing/overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_ADDR_W  = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     Rx,
  uart_rx_if.slave host
);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int AW    = FIFO_ADDR_W;
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tick_half, tick_full;
  logic          sample_bit, push, ovr_set, fe_set;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop;
  logic          frame_err, overrun;

  // Two-flop synchroniser; idle-high so reset looks like an idle line.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick_half = (cnt == HALF_M1);
  assign tick_full = (cnt == FULL_M1);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rx_s) state_nxt = S_START;
      S_START: if (tick_half) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick_full && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (tick_full) state_nxt = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sample_bit = 1'b0;
    push       = 1'b0;
    ovr_set    = 1'b0;
    fe_set     = 1'b0;
    case (state)
      S_DATA: sample_bit = tick_full;
      S_STOP: if (tick_full) begin
        push    = rx_s && (!full || host.RxFifoRead);
        ovr_set = rx_s && full && !host.RxFifoRead;
        fe_set  = !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + CW'(1);
      if (sample_bit) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = host.RxFifoRead && !empty;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      frame_err <= (frame_err && !host.ErrorClear) || fe_set;
      overrun   <= (overrun && !host.ErrorClear) || ovr_set;
    end
  end

  assign host.RxData       = mem[rd_ptr[AW-1:0]];
  assign host.RxFifoEmpty  = empty;
  assign host.RxFifoFull   = full;
  assign host.RxFrameError = frame_err;
  assign host.RxOverrun    = overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a queue-level receive model checked every cycle,
// plus hand-computed expectations for the test-plan scenarios.
module tb_uart_rx;
  localparam int N     = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  // Pin edge at cycle c -> stop decision at c + 2 (sync) + N/2 (mid start) + 9*N.
  localparam int STOP_LAT = 2 + N / 2 + 9 * N;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic Rx    = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(N), .FIFO_ADDR_W(AW)) dut (
    .clock(clock),
    .reset(reset),
    .Rx   (Rx),
    .host (bus)
  );

  always #5 clock = ~clock;

  // Model: byte queue, sticky flags, and frame outcomes scheduled by cycle.
  logic [7:0] q[$];
  bit         m_fe = 1'b0, m_ov = 1'b0;
  int         ev_cyc[$];
  bit         ev_ok[$];
  logic [7:0] ev_b[$];

  function automatic void check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clock) begin
    bit rd, full0, push, fe_set, ov_set;
    logic [7:0] pb;
    if (reset) begin
      q.delete();
      m_fe = 1'b0;
      m_ov = 1'b0;
    end else begin
      rd = bus.RxFifoRead;
      full0 = (q.size() == DEPTH);
      push = 1'b0; fe_set = 1'b0; ov_set = 1'b0; pb = 8'h00;
      if (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
        if (ev_ok[0]) begin
          if (!full0 || rd) begin push = 1'b1; pb = ev_b[0]; end
          else ov_set = 1'b1;
        end else fe_set = 1'b1;
        void'(ev_cyc.pop_front()); void'(ev_ok.pop_front()); void'(ev_b.pop_front());
      end
      if (rd && q.size() > 0) void'(q.pop_front());
      if (push) q.push_back(pb);
      if (bus.ErrorClear) begin m_fe = 1'b0; m_ov = 1'b0; end
      if (fe_set) m_fe = 1'b1;
      if (ov_set) m_ov = 1'b1;
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("cmp_empty", 8'(bus.RxFifoEmpty), 8'(q.size() == 0));
      check("cmp_full",  8'(bus.RxFifoFull),  8'(q.size() == DEPTH));
      check("cmp_ferr",  8'(bus.RxFrameError), 8'(m_fe));
      check("cmp_ovr",   8'(bus.RxOverrun),   8'(m_ov));
      if (q.size() > 0) check("cmp_data", bus.RxData, q[0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge; drives one 8N1 frame and schedules its outcome.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    ev_cyc.push_back(cyc + STOP_LAT);
    ev_ok.push_back(stop_bit);
    ev_b.push_back(b);
    Rx = 1'b0;
    tick(N);
    for (int k = 0; k < 8; k++) begin
      Rx = b[k];
      tick(N);
    end
    Rx = stop_bit;
    tick(N);
  endtask

  task automatic read_expect(input string nm, input logic [7:0] exp);
    check(nm, bus.RxData, exp);
    bus.RxFifoRead = 1'b1;
    tick(1);
    bus.RxFifoRead = 1'b0;
  endtask

  initial begin
    int c0, fall;
    bus.RxFifoRead = 1'b0;
    bus.ErrorClear = 1'b0;

    // Reset defaults
    tick(3);
    reset = 1'b0;
    check("rst_empty", 8'(bus.RxFifoEmpty), 8'd1);
    check("rst_full",  8'(bus.RxFifoFull),  8'd0);
    check("rst_ferr",  8'(bus.RxFrameError), 8'd0);
    check("rst_ovr",   8'(bus.RxOverrun),   8'd0);
    tick(10);

    // Single byte with exact fall time of RxFifoEmpty
    c0 = cyc;
    fall = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 300; i++) begin
          if (!bus.RxFifoEmpty) begin fall = cyc; break; end
          tick(1);
        end
      end
    join
    check("single_fall_cycle", 8'(fall - c0), 8'(STOP_LAT + 1));
    check("single_data", bus.RxData, 8'hA5);
    read_expect("single_read", 8'hA5);
    check("single_empty_after_read", 8'(bus.RxFifoEmpty), 8'd1);
    tick(10);

    // Back-to-back frames and overrun
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    check("b2b_full", 8'(bus.RxFifoFull), 8'd1);
    check("b2b_no_ovr_yet", 8'(bus.RxOverrun), 8'd0);
    send_frame(8'h7E, 1'b1);
    check("b2b_ovr", 8'(bus.RxOverrun), 8'd1);
    read_expect("b2b_rd0", 8'h00);
    read_expect("b2b_rd1", 8'hFF);
    read_expect("b2b_rd2", 8'h3C);
    read_expect("b2b_rd3", 8'h81);
    check("b2b_empty", 8'(bus.RxFifoEmpty), 8'd1);
    tick(10);

    // Framing error, held-low line, recovery
    send_frame(8'h55, 1'b0);
    tick(40);
    Rx = 1'b1;
    check("fe_flag", 8'(bus.RxFrameError), 8'd1);
    check("fe_empty", 8'(bus.RxFifoEmpty), 8'd1);
    tick(10);
    send_frame(8'h12, 1'b1);
    read_expect("fe_next_byte", 8'h12);
    bus.ErrorClear = 1'b1;
    tick(1);
    bus.ErrorClear = 1'b0;
    check("clr_ferr", 8'(bus.RxFrameError), 8'd0);
    check("clr_ovr",  8'(bus.RxOverrun),   8'd0);
    tick(10);

    // Glitch rejection
    Rx = 1'b0;
    tick(5);
    Rx = 1'b1;
    tick(3 * N);
    check("glitch_empty", 8'(bus.RxFifoEmpty), 8'd1);
    check("glitch_ferr",  8'(bus.RxFrameError), 8'd0);
    tick(10);

    // Full FIFO with a read on the push cycle of the next byte
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    check("bnd_full_before", 8'(bus.RxFifoFull), 8'd1);
    check("bnd_head", bus.RxData, 8'h01);
    c0 = cyc;
    fork
      send_frame(8'h99, 1'b1);
      begin
        while (cyc < c0 + STOP_LAT) tick(1);
        bus.RxFifoRead = 1'b1;
        tick(1);
        bus.RxFifoRead = 1'b0;
      end
    join
    check("bnd_full_after", 8'(bus.RxFifoFull), 8'd1);
    check("bnd_no_ovr", 8'(bus.RxOverrun), 8'd0);
    read_expect("bnd_rd0", 8'h02);
    read_expect("bnd_rd1", 8'h03);
    read_expect("bnd_rd2", 8'h04);
    read_expect("bnd_rd3", 8'h99);
    check("bnd_empty", 8'(bus.RxFifoEmpty), 8'd1);
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
